// File: rtl/line_buffer_ctrl.sv
// rtl/line_buffer_ctrl.sv - 4-line-buffer 3x3 window sequencer (option: LBC_INTR_STICKY_EN)
module line_buffer_ctrl #(
  parameter int IMAGE_WIDTH = 512,
  parameter int IW_BIT_NUM  = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_data_valid,
  input  logic [7:0] s_data,
  output logic       s_data_ready,
  output logic [3:0] lb_wr_en,
  output logic [7:0] lb_wr_data,
  output logic [3:0] lb_rd_en,
  output logic [1:0] lb_rd_sel,
  input  logic       m_data_ready,
  output logic       pixel_window_valid,
  output logic [2:0] fill_cnt,
  output logic       intr_out
);

  localparam logic [IW_BIT_NUM-1:0] LAST_PIX = IW_BIT_NUM'(IMAGE_WIDTH - 1);
  localparam logic [IW_BIT_NUM-1:0] PIX_ONE  = IW_BIT_NUM'(1);

  typedef enum logic {IDLE, READ} state_t;

  state_t                state, next_state;
  logic [1:0]            wr_sel;
  logic [IW_BIT_NUM-1:0] wr_pix_cnt;
  logic [IW_BIT_NUM-1:0] rd_pix_cnt;
  logic                  accept;
  logic                  row_written;
  logic                  advance;
  logic                  row_read;

  // Write side: a full set of four rows blocks the source
  assign s_data_ready = (fill_cnt != 3'd4);
  assign accept       = s_data_valid & s_data_ready;
  assign row_written  = accept && (wr_pix_cnt == LAST_PIX);
  assign lb_wr_en     = accept ? (4'b0001 << wr_sel) : 4'b0000;
  assign lb_wr_data   = s_data;
  assign row_read     = advance && (rd_pix_cnt == LAST_PIX);

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Read FSM next state and the three-row read enables around lb_rd_sel
  always_comb begin
    next_state = state;
    advance    = 1'b0;
    lb_rd_en   = 4'b0000;
    case (state)
      IDLE: begin
        if (fill_cnt >= 3'd3) next_state = READ;
      end
      READ: begin
        if (m_data_ready) begin
          advance = 1'b1;
          case (lb_rd_sel)
            2'd0:    lb_rd_en = 4'b0111;
            2'd1:    lb_rd_en = 4'b1110;
            2'd2:    lb_rd_en = 4'b1101;
            default: lb_rd_en = 4'b1011;
          endcase
          if (rd_pix_cnt == LAST_PIX) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Write pointer: column count and round-robin buffer select
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_pix_cnt <= '0;
      wr_sel     <= 2'd0;
    end else if (accept) begin
      if (row_written) begin
        wr_pix_cnt <= '0;
        wr_sel     <= wr_sel + 2'd1;
      end else begin
        wr_pix_cnt <= wr_pix_cnt + PIX_ONE;
      end
    end
  end

  // Read pointer, window-valid (one-cycle buffer latency) and top-row select
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pix_cnt         <= '0;
      lb_rd_sel          <= 2'd0;
      pixel_window_valid <= 1'b0;
    end else begin
      pixel_window_valid <= advance;
      if (advance) begin
        if (row_read) begin
          rd_pix_cnt <= '0;
          lb_rd_sel  <= lb_rd_sel + 2'd1;
        end else begin
          rd_pix_cnt <= rd_pix_cnt + PIX_ONE;
        end
      end
    end
  end

  // Rows held: a simultaneous write and read leave the count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_cnt <= 3'd0;
    end else begin
      case ({row_written, row_read})
        2'b10:   fill_cnt <= fill_cnt + 3'd1;
        2'b01:   fill_cnt <= fill_cnt - 3'd1;
        default: fill_cnt <= fill_cnt;
      endcase
    end
  end

  // Row-freed interrupt: pulse, or level cleared by the next accepted pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      intr_out <= 1'b0;
    end else begin
`ifdef LBC_INTR_STICKY_EN
      if (row_read)    intr_out <= 1'b1;
      else if (accept) intr_out <= 1'b0;
`else
      intr_out <= row_read;
`endif
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb/tb_line_buffer_ctrl.sv - directed bench for line_buffer_ctrl
module tb_line_buffer_ctrl;

  localparam int W     = 512;
  localparam int BOUND = 4000;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_data_valid;
  logic [7:0] s_data;
  logic       s_data_ready;
  logic [3:0] lb_wr_en;
  logic [7:0] lb_wr_data;
  logic [3:0] lb_rd_en;
  logic [1:0] lb_rd_sel;
  logic       m_data_ready;
  logic       pixel_window_valid;
  logic [2:0] fill_cnt;
  logic       intr_out;

  int n_pass  = 0;
  int n_total = 0;
  int win_cnt = 0;
  int intr_cnt = 0;
  int win_at_intr = 0;
  int win_base;
  int intr_base;
  logic [3:0] rd_pat [4];

  line_buffer_ctrl #(.IMAGE_WIDTH(W), .IW_BIT_NUM(9)) dut (
    .clk                (clk),
    .reset              (reset),
    .s_data_valid       (s_data_valid),
    .s_data             (s_data),
    .s_data_ready       (s_data_ready),
    .lb_wr_en           (lb_wr_en),
    .lb_wr_data         (lb_wr_data),
    .lb_rd_en           (lb_rd_en),
    .lb_rd_sel          (lb_rd_sel),
    .m_data_ready       (m_data_ready),
    .pixel_window_valid (pixel_window_valid),
    .fill_cnt           (fill_cnt),
    .intr_out           (intr_out)
  );

  always #5 clk = ~clk;

  // Tally window-valid cycles and interrupt cycles away from the active edge
  always @(negedge clk) begin
    if (pixel_window_valid) win_cnt = win_cnt + 1;
    if (intr_out) begin
      intr_cnt    = intr_cnt + 1;
      win_at_intr = win_cnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_data_valid = 1'b0;
    tick(3);
    reset = 1'b0;
  endtask

  // One row, one pixel per cycle whenever ready; checks the write enable on the first pixel
  task automatic send_row(input int exp_sel);
    int w;
    for (int i = 0; i < W; i++) begin
      s_data_valid = 1'b1;
      s_data       = 8'(i);
      #1;
      w = 0;
      while (!s_data_ready && w < BOUND) begin
        @(posedge clk);
        #2;
        w++;
      end
      if (w >= BOUND) check("ready_timeout", 0, 1);
      if (i == 0) begin
        check("wr_en_first", 32'(lb_wr_en), 32'(4'b0001 << exp_sel));
        check("wr_data", 32'(lb_wr_data), 0);
      end
      @(posedge clk);
      #1;
    end
    s_data_valid = 1'b0;
  endtask

  task automatic wait_intr();
    int w = 0;
    while (!intr_out && w < BOUND) begin
      tick(1);
      w++;
    end
    if (w >= BOUND) check("intr_timeout", 0, 1);
  endtask

  task automatic wait_read();
    int w = 0;
    while (lb_rd_en == 4'b0000 && w < BOUND) begin
      tick(1);
      w++;
    end
    if (w >= BOUND) check("read_timeout", 0, 1);
  endtask

  initial begin
    rd_pat[0] = 4'b0111;
    rd_pat[1] = 4'b1110;
    rd_pat[2] = 4'b1101;
    rd_pat[3] = 4'b1011;
    reset = 1'b1;
    s_data_valid = 1'b0;
    s_data = 8'd0;
    m_data_ready = 1'b0;

    // Reset values
    do_reset();
    #1;
    check("rst_ready", 32'(s_data_ready), 1);
    check("rst_fill", 32'(fill_cnt), 0);
    check("rst_wr_en", 32'(lb_wr_en), 0);
    check("rst_rd_en", 32'(lb_rd_en), 0);
    check("rst_intr", 32'(intr_out), 0);
    check("rst_pwv", 32'(pixel_window_valid), 0);
    check("rst_rd_sel", 32'(lb_rd_sel), 0);

    // Fill all four buffers with reads stalled, then offer one more pixel
    for (int r = 0; r < 4; r++) send_row(r);
    check("full_fill", 32'(fill_cnt), 4);
    check("full_ready", 32'(s_data_ready), 0);
    s_data_valid = 1'b1;
    s_data = 8'hAA;
    #1;
    check("blocked_wr_en", 32'(lb_wr_en), 0);
    check("stalled_rd_en", 32'(lb_rd_en), 0);
    tick(3);
    check("blocked_fill", 32'(fill_cnt), 4);
    check("stalled_pwv", 32'(pixel_window_valid), 0);
    s_data_valid = 1'b0;

    // Three rows with the sink ready: latency, window count, one interrupt
    do_reset();
    m_data_ready = 1'b1;
    win_base  = win_cnt;
    intr_base = intr_cnt;
    for (int r = 0; r < 3; r++) send_row(r);
    check("three_fill", 32'(fill_cnt), 3);
    check("idle_bubble_rd_en", 32'(lb_rd_en), 0);
    tick(1);
    check("first_rd_en", 32'(lb_rd_en), 32'(4'b0111));
    check("first_pwv_early", 32'(pixel_window_valid), 0);
    tick(1);
    check("first_pwv", 32'(pixel_window_valid), 1);
    wait_intr();
    tick(3);
    check("row_windows", win_cnt - win_base, 512);
    check("row_intr", intr_cnt - intr_base, 1);
    check("row_fill", 32'(fill_cnt), 2);
    check("row_rd_sel", 32'(lb_rd_sel), 1);

    // Six rows paced by the interrupt; write select wraps and read select walks 1..3,0..2
    for (int k = 0; k < 6; k++) begin
      send_row((3 + k) % 4);
      wait_read();
      check("pace_rd_sel", 32'(lb_rd_sel), (1 + k) % 4);
      check("pace_rd_en", 32'(lb_rd_en), 32'(rd_pat[(1 + k) % 4]));
      wait_intr();
      tick(1);
    end
    check("pace_fill", 32'(fill_cnt), 2);
    check("pace_rd_sel_end", 32'(lb_rd_sel), 3);

    // Sink ready toggling every cycle during a row read
    do_reset();
    m_data_ready = 1'b0;
    for (int r = 0; r < 3; r++) send_row(r);
    win_base  = win_cnt;
    intr_base = intr_cnt;
    begin
      int w = 0;
      while (!intr_out && w < BOUND) begin
        m_data_ready = ~m_data_ready;
        tick(1);
        w++;
      end
      if (w >= BOUND) check("toggle_timeout", 0, 1);
    end
    m_data_ready = 1'b1;
    tick(3);
    check("toggle_windows", win_cnt - win_base, 512);
    check("toggle_win_at_intr", win_at_intr - win_base, 512);
    check("toggle_intr", intr_cnt - intr_base, 1);
    check("toggle_fill", 32'(fill_cnt), 2);

    // Last write of row 5 lands on the same edge as the last read advance of the row-4 window
    send_row(3);
    tick(1);
    send_row(0);
    check("align_fill", 32'(fill_cnt), 3);
    check("align_intr", 32'(intr_out), 1);
    tick(2);
    check("reread_rd_en", 32'(lb_rd_en), 32'(4'b1101));
    reset = 1'b1;
    tick(1);
    check("midrst_fill", 32'(fill_cnt), 0);
    check("midrst_rd_en", 32'(lb_rd_en), 0);
    check("midrst_rd_sel", 32'(lb_rd_sel), 0);
    check("midrst_pwv", 32'(pixel_window_valid), 0);
    reset = 1'b0;
    tick(2);
    check("postrst_idle", 32'(lb_rd_en), 0);
    check("postrst_ready", 32'(s_data_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
